// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential one-element-per-clock argmax over the final dense-layer outputs
module argmax_classifier #(
  parameter int NEURONS = 4,
  parameter int FMT = 0,
  parameter int IDXW = ($clog2(NEURONS) < 1) ? 1 : $clog2(NEURONS)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     inputs [0:NEURONS-1],
  output logic [IDXW-1:0] class_idx,
  output logic [31:0]     max_val,
  output logic            done,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [31:0] snap [0:NEURONS-1];
  logic [31:0] best_val, best_key, cur, cur_key;
  logic [IDXW-1:0] cnt, best_idx;
  logic take, last;
  // Monotonic unsigned key; floats fold -0 onto +0 and push NaN to the bottom
  function automatic logic [31:0] key(input logic [31:0] x);
    return (FMT == 0) ? x ^ 32'h8000_0000 :
           (x[30:23] == 8'hff && x[22:0] != '0) ? 32'h0 :
           (x == 32'h8000_0000) ? 32'h8000_0000 :
           x[31] ? ~x : x ^ 32'h8000_0000;
  endfunction
  always_comb begin
    cur = snap[cnt];
    cur_key = key(cur);
    take = (cnt == '0) || (cur_key > best_key);
    last = (cnt == IDXW'(NEURONS - 1));
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < NEURONS; i++) snap[i] <= '0;
      best_val <= '0;
      best_key <= '0;
      best_idx <= '0;
      cnt <= '0;
      class_idx <= '0;
      max_val <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap <= inputs;
          cnt <= '0;
          busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          if (take) begin
            best_val <= cur;
            best_key <= cur_key;
            best_idx <= cnt;
          end
          cnt <= cnt + 1'b1;
          if (last) begin
            class_idx <= take ? cnt : best_idx;
            max_val <= take ? cur : best_val;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed checks of a fixed-point and a float instance fed the same stimulus
module tb_argmax_classifier;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] in_v [0:3];
  logic [1:0] idx0, idx1;
  logic [31:0] val0, val1;
  logic done0, done1, busy0, busy1;
  int checks = 0, errors = 0, dc = 0;

  always #5 clk = ~clk;

  argmax_classifier #(.NEURONS(4), .FMT(0)) dut0 (
    .CLK(clk), .reset(reset), .start(start), .inputs(in_v),
    .class_idx(idx0), .max_val(val0), .done(done0), .busy(busy0));
  argmax_classifier #(.NEURONS(4), .FMT(1)) dut1 (
    .CLK(clk), .reset(reset), .start(start), .inputs(in_v),
    .class_idx(idx1), .max_val(val1), .done(done1), .busy(busy1));

  always @(negedge clk) if (done0) dc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] a, b, c, d);
    in_v[0] = a; in_v[1] = b; in_v[2] = c; in_v[3] = d;
  endtask

  task automatic do_scan(input string tag);
    int bc = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bc += int'(busy0);
      chk({tag, " early_done"}, 32'(done0), 32'd0);
      @(posedge clk) #1;
    end
    chk({tag, " busy_cycles"}, 32'(bc), 32'd4);
    chk({tag, " done_rise"}, {30'd0, done0, busy0}, 32'b10);
    @(posedge clk) #1;
    chk({tag, " done_fall"}, 32'(done0), 32'd0);
  endtask

  initial begin
    int d0;
    set_in(0, 0, 0, 0);
    #2;
    chk("rst idx", 32'(idx0), 0);
    chk("rst val", val0, 0);
    chk("rst flags", {30'd0, done0, busy0}, 0);
    @(negedge clk) reset = 1'b0;

    set_in(32'h5, 32'hFFFF_FFFD, 32'h9, 32'h9);
    do_scan("tie");
    chk("tie idx", 32'(idx0), 2);
    chk("tie val", val0, 32'h9);

    set_in(32'hBF80_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h3F80_0000);
    do_scan("nan");
    chk("nan idx", 32'(idx1), 1);
    chk("nan val", val1, 32'h4000_0000);

    set_in(32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'hC120_0000);
    do_scan("neg");
    chk("neg idx", 32'(idx1), 1);
    chk("neg val", val1, 32'hBF80_0000);

    set_in(32'h8000_0000, 32'h0, 32'hBF80_0000, 32'hBF80_0000);
    do_scan("zero");
    chk("zero idx", 32'(idx1), 0);
    chk("zero val", val1, 32'h8000_0000);

    set_in(32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 32'h7FC0_0000);
    do_scan("allnan");
    chk("allnan idx", 32'(idx1), 0);
    chk("allnan val", val1, 32'h7FC0_0000);

    set_in(1, 2, 3, 4);
    d0 = dc;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1;
    @(negedge clk) set_in(9, 0, 0, 0);
    @(posedge clk) #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("iso pulses", 32'(dc - d0), 1);
    chk("iso idx", 32'(idx0), 3);
    chk("iso val", val0, 4);
    do_scan("after");
    chk("after idx", 32'(idx0), 0);
    chk("after val", val0, 9);

    set_in(7, 1, 1, 1);
    d0 = dc;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid idx", 32'(idx0), 0);
    chk("mid val", val0, 0);
    chk("mid busy", 32'(busy0), 0);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("mid nodone", 32'(dc - d0), 0);
    do_scan("re");
    chk("re idx", 32'(idx0), 0);
    chk("re val", val0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Output stage directly downstream of the dense `layer` module.
- Consumes the N 32-bit neuron outputs of the final layer and sequentially scans them to find the winning class.
- Reports the class index and the winning value with a start/done handshake.
- Scans one element per clock, so the comparator footprint stays independent of N.

Parameters:
- NEURONS, 4, number of 32-bit inputs scanned; must be at least 2.
- FMT, 0, number format of the inputs: 0 = 32-bit two's-complement signed, 1 = IEEE-754 single precision.
- IDXW, $clog2(NEURONS), width of class_idx; forced to at least 1.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a scan; sampled only in IDLE.
- inputs  input  32 x NEURONS (unpacked array [0:NEURONS-1])  neuron outputs from the dense layer.
- class_idx  output  IDXW  index of the maximum element.
- max_val  output  32  raw 32-bit value of the maximum element.
- done  output  1  single-cycle pulse when results are updated.
- busy  output  1  high while a scan is in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - class_idx=0, max_val=0, done=0, busy=0.
  - The snapshot register, the running max and the index counter are cleared.
  - Takes effect mid-scan with no partial result published.
  - After reset deasserts, the first start is accepted normally.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On an edge with start=1, copy all of `inputs` into the snapshot register.
  - Set the scan counter to 0 and busy=1, then go to SCAN.
- SCAN:
  - On each edge, compare snapshot[cnt] against the running best, then increment cnt.
  - Element 0 unconditionally initialises the best.
  - When cnt reaches NEURONS-1, write class_idx and max_val from the final best and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - A start asserted during DONE is ignored.
- Latency:
  - start is sampled at edge k.
  - Elements are processed at edges k+1 .. k+NEURONS.
  - Outputs update and done rises after edge k+NEURONS, and done falls after edge k+NEURONS+1.
- Outputs hold their last values until the next scan completes or reset occurs.
- Snapshot isolation: changes on `inputs` after the start edge have no effect on the result.
- start while busy: ignored and not queued.
- Ties: strict greater-than comparison, so the lowest index wins.
- Comparison key for FMT=0: key = x XOR 0x80000000, compared unsigned.
- Comparison key for FMT=1:
  - Positive values (sign 0): key = x XOR 0x80000000.
  - Negative values (sign 1): key = NOT x.
  - -0 (0x80000000) maps to the +0 key, so -0 and +0 compare equal.
  - NaN (exponent 0xFF with mantissa != 0) maps to key 0, the lowest. A NaN wins only if every element is NaN, in which case class_idx=0.
  - +/-Inf are ordered normally.
- max_val always carries the original raw bits, never the key.
- Pure compare and select: no arithmetic on values, so no overflow cases.

Test Plan:
- Fixed-point tie, FMT=0, NEURONS=4:
  - Stimulus: inputs {0x00000005, 0xFFFFFFFD, 0x00000009, 0x00000009}, pulse start.
  - Required: class_idx=2, max_val=0x00000009; done is a 1-cycle pulse after the 4th edge following the start edge; busy is high for exactly those 4 cycles.
- Float with NaN, FMT=1:
  - Stimulus: inputs {0xBF800000, 0x40000000, 0x7FC00000, 0x3F800000}.
  - Required: class_idx=1, max_val=0x40000000.
- All negative and signed zero, FMT=1:
  - Stimulus: inputs {0xC0000000, 0xBF800000, 0xC0400000, 0xC1200000}.
  - Required: class_idx=1, max_val=0xBF800000.
  - Second stimulus: {0x80000000, 0x00000000, 0xBF800000, 0xBF800000} gives class_idx=0, max_val=0x80000000.
- Snapshot isolation and start while busy, FMT=0:
  - Stimulus: start with {1,2,3,4}; one cycle later change inputs to {9,0,0,0} and pulse start again.
  - Required: class_idx=3, max_val=4, and only one done pulse.
  - A start issued after done then yields class_idx=0, max_val=9.
- Reset mid-scan:
  - Stimulus: assert reset 2 cycles into a scan of {7,1,1,1}.
  - Required: class_idx=0, max_val=0, busy=0 immediately, with no done pulse.
  - Required: the next start completes correctly with class_idx=0, max_val=7.
